dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the processor datapath's load/store path and a host (loader/debug) port. It sits between the datapath's data-memory request signals and the DataMemory instance, granting at most one access per cycle. The CPU has default priority, and a streak counter bounds host starvation. It also produces the stall signal that freezes the PC while a CPU access is denied.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and memory
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive CPU grants while host_req is pending; legal range 1..15

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, held until granted
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU byte address
- cpu_wdata  input  DATA_W  CPU store data
- cpu_gnt  output  1  CPU access performed this cycle (combinational)
- cpu_stall  output  1  cpu_req & ~cpu_gnt; datapath holds PC and register writes
- cpu_rvalid  output  1  registered; read data for CPU valid this cycle
- cpu_rdata  output  DATA_W  registered CPU read data
- host_req, host_we, host_addr, host_wdata  input  1/1/ADDR_W/DATA_W  host request, same semantics as CPU
- host_gnt  output  1  host access performed this cycle
- host_rvalid  output  1  registered; read data for host valid
- host_rdata  output  DATA_W  registered host read data
- mem_addr  output  ADDR_W  to DataMemory address
- mem_wdata  output  DATA_W  to DataMemory write data
- mem_read  output  1  DataMemory read enable
- mem_write  output  1  DataMemory write enable
- mem_rdata  input  DATA_W  DataMemory read data, valid in the same cycle as mem_read

## Operation
- Owner state register, values IDLE / CPU / HOST, holding the last granted requester. It updates every cycle: CPU if cpu_gnt, HOST if host_gnt, IDLE if neither.
- Streak counter cnt, width 4 bits:
  - cnt+1 when cpu_gnt & host_req.
  - Cleared when host_gnt, or when host_req = 0.
  - Saturates at MAX_BURST.
- Grant rule, evaluated combinationally each cycle:
  - Only host_req: host granted.
  - Only cpu_req: CPU granted.
  - Both, cnt < MAX_BURST: CPU granted.
  - Both, cnt == MAX_BURST: host granted (forced turn).
  - Neither: no grant; mem_read = mem_write = 0.
- Exactly zero or one of cpu_gnt / host_gnt is high in any cycle.
- Memory signals come from the granted requester:
  - mem_addr / mem_wdata are muxed from the granted requester; with no grant they hold the CPU inputs.
  - mem_write = gnt & we.
  - mem_read = gnt & ~we.
- Read return: on a granted read, mem_rdata is captured at the clock edge into that requester's rdata register. The matching rvalid is high for exactly the next cycle.
- Writes produce no rvalid.
- rdata registers hold their last value when rvalid = 0.
- Requesters must keep req/we/addr/wdata stable until gnt. A request dropped before grant is discarded with no side effect.

## Timing
- Grant latency:
  - Lone requester: 0 cycles (gnt in the same cycle as req).
  - Host contending: at most MAX_BURST cycles.
  - CPU contending: at most 1 cycle, since the forced host turn is a single grant.
- Read data latency: rvalid one cycle after gnt.
- Back-to-back granted reads give rvalid on consecutive cycles.
- Reset low, asynchronous:
  - owner = IDLE, cnt = 0.
  - cpu_rvalid = host_rvalid = 0.
  - cpu_rdata = host_rdata = 0.
  - While reset is low, cpu_gnt = host_gnt = mem_read = mem_write = 0 and cpu_stall = cpu_req.
- Reset asserted mid-access: the access is dropped and no rvalid is produced. Arbitration restarts with cnt = 0 on the first edge after release.
- Host request arriving in the same cycle cnt would increment: it counts, so a continuously requesting host is granted on cycle MAX_BURST+1 at the latest.
- A host read granted in the cycle right after a CPU read gives cpu_rvalid then host_rvalid on consecutive cycles, never both in one cycle.

## Test plan
- Reset values: pulse reset low mid-cycle with both requests high -> all gnt/rvalid/mem enables 0 immediately; rdata = 0; cpu_stall = 1.
- Lone CPU store then load: cpu_req, we = 1, addr 0x10, wdata 0xDEADBEEF, then read of 0x10 -> cpu_gnt both cycles, mem_write then mem_read, cpu_rvalid with 0xDEADBEEF one cycle after the read grant, cpu_stall = 0 throughout.
- Contention fairness (MAX_BURST = 4): both requesting continuously -> grant pattern CPU×4, HOST, CPU×4, HOST. cpu_stall is high only on the host cycles.
- Host alone: host read of 0x20 after the CPU wrote 0x12345678 there -> host_gnt same cycle, host_rvalid + host_rdata = 0x12345678 next cycle, cpu_rvalid stays 0.
- Counter clear: 3 CPU grants with host_req high, host drops, then re-asserts -> cnt restarted, so the host is granted after 4 more CPU grants, not 1.
- Reset mid-read: reset low in the cycle of a granted CPU read -> no cpu_rvalid after release; first post-reset contention again follows CPU×MAX_BURST then HOST.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store path and a
// host (loader/debug) port. At most one access is granted per cycle. The CPU
// wins by default; a streak counter forces a single host turn after MAX_BURST
// consecutive CPU grants while the host is waiting.
//
// Ports:
//   clk, reset                       clock, async active-low reset
//   cpu_req/we/addr/wdata            CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_stall               grant (comb), stall = req & ~gnt
//   cpu_rvalid, cpu_rdata            read return, one cycle after grant
//   host_req/we/addr/wdata           host request, same semantics
//   host_gnt, host_rvalid, host_rdata
//   mem_addr/wdata/read/write        to DataMemory
//   mem_rdata                        from DataMemory, valid with mem_read
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_HOST} owner_t;

  owner_t            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q;            // last granted access was a read
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  // Grants are gated by reset so nothing reaches memory while reset is low.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    owner_d  = OWN_IDLE;
    cnt_d    = cnt_q;
    if (reset) begin
      if (host_req && (!cpu_req || cnt_q == MAXB)) host_gnt = 1'b1;
      else if (cpu_req)                            cpu_gnt  = 1'b1;
    end
    if (cpu_gnt)       owner_d = OWN_CPU;
    else if (host_gnt) owner_d = OWN_HOST;
    // A host that stops waiting loses its accumulated claim.
    if (!host_req || host_gnt)           cnt_d = 4'd0;
    else if (cpu_gnt && cnt_q < MAXB)    cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_IDLE;
      cnt_q        <= 4'd0;
      rd_q         <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rd_q    <= mem_read;
      if (cpu_gnt  && !cpu_we)  cpu_rdata_q  <= mem_rdata;
      if (host_gnt && !host_we) host_rdata_q <= mem_rdata;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign mem_addr    = host_gnt ? host_addr  : cpu_addr;
  assign mem_wdata   = host_gnt ? host_wdata : cpu_wdata;
  assign mem_write   = (cpu_gnt & cpu_we)  | (host_gnt & host_we);
  assign mem_read    = (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
  // The owner register says whose read is returning this cycle.
  assign cpu_rvalid  = rd_q & (owner_q == OWN_CPU);
  assign host_rvalid = rd_q & (owner_q == OWN_HOST);
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DataMemory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int nchk = 0;
  int nerr = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_host(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  logic exp_h, prev_c, prev_h;
  logic hreq_pat [0:8];

  initial begin
    reset = 1'b0;
    drv_cpu(0, 0, 0, 0);
    drv_host(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset pulsed mid-cycle with both requesting
    drv_cpu(1, 0, 32'h0, 0);
    drv_host(1, 0, 32'h4, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst cpu_gnt", cpu_gnt, 0);
    chk("rst host_gnt", host_gnt, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst cpu_stall", cpu_stall, 1);
    @(posedge clk); #1;
    chk("rst cpu_rvalid", cpu_rvalid, 0);
    chk("rst host_rvalid", host_rvalid, 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst host_rdata", host_rdata, 0);
    chk("rst gnt held", {cpu_gnt, host_gnt}, 0);
    @(negedge clk);
    drv_cpu(0, 0, 0, 0);
    drv_host(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    // Lone CPU store then load
    drv_cpu(1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("st cpu_gnt", cpu_gnt, 1);
    chk("st mem_write", mem_write, 1);
    chk("st mem_read", mem_read, 0);
    chk("st mem_addr", mem_addr, 32'h10);
    chk("st mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st stall", cpu_stall, 0);
    @(negedge clk);
    drv_cpu(1, 0, 32'h10, 0);
    #1;
    chk("ld cpu_gnt", cpu_gnt, 1);
    chk("ld mem_read", mem_read, 1);
    chk("ld mem_write", mem_write, 0);
    chk("ld stall", cpu_stall, 0);
    chk("st no rvalid", cpu_rvalid, 0);
    @(negedge clk);
    drv_cpu(1, 1, 32'h20, 32'h12345678);
    #1;
    chk("ld cpu_rvalid", cpu_rvalid, 1);
    chk("ld cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("st2 cpu_gnt", cpu_gnt, 1);
    @(negedge clk);
    drv_cpu(0, 0, 0, 0);

    // Host alone reads what the CPU wrote
    drv_host(1, 0, 32'h20, 0);
    #1;
    chk("h host_gnt", host_gnt, 1);
    chk("h cpu_gnt", cpu_gnt, 0);
    chk("h mem_read", mem_read, 1);
    chk("h mem_addr", mem_addr, 32'h20);
    @(negedge clk);
    drv_host(0, 0, 0, 0);
    #1;
    chk("h host_rvalid", host_rvalid, 1);
    chk("h host_rdata", host_rdata, 32'h12345678);
    chk("h cpu_rvalid", cpu_rvalid, 0);
    @(negedge clk);
    #1;
    chk("h rvalid drop", host_rvalid, 0);
    chk("h rdata hold", host_rdata, 32'h12345678);
    chk("idle cpu_rdata hold", cpu_rdata, 32'hDEADBEEF);

    // Continuous contention: CPU x4, HOST, CPU x4, HOST
    @(negedge clk);
    drv_cpu(1, 0, 32'h10, 0);
    drv_host(1, 0, 32'h20, 0);
    prev_c = 0; prev_h = 0;
    for (int i = 0; i < 10; i++) begin
      exp_h = (i % 5 == 4);
      #1;
      chk($sformatf("ct%0d host_gnt", i), host_gnt, exp_h);
      chk($sformatf("ct%0d cpu_gnt", i), cpu_gnt, !exp_h);
      chk($sformatf("ct%0d stall", i), cpu_stall, exp_h);
      chk($sformatf("ct%0d cpu_rvalid", i), cpu_rvalid, prev_c);
      chk($sformatf("ct%0d host_rvalid", i), host_rvalid, prev_h);
      if (prev_h) chk($sformatf("ct%0d host_rdata", i), host_rdata, 32'h12345678);
      prev_c = !exp_h; prev_h = exp_h;
      @(negedge clk);
    end

    // Counter clear: host drops after 3 CPU grants, then waits 4 more
    hreq_pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    for (int j = 0; j < 9; j++) begin
      host_req = hreq_pat[j];
      #1;
      chk($sformatf("cc%0d host_gnt", j), host_gnt, (j == 8));
      chk($sformatf("cc%0d cpu_gnt", j), cpu_gnt, (j != 8));
      @(negedge clk);
    end

    // Reset during a granted CPU read
    drv_host(0, 0, 0, 0);
    #1;
    chk("rr cpu_gnt", cpu_gnt, 1);
    #1 reset = 1'b0;
    #1;
    chk("rr gnt gated", cpu_gnt, 0);
    chk("rr stall", cpu_stall, 1);
    @(negedge clk);
    reset = 1'b1;
    drv_host(1, 0, 32'h20, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 0) chk("rr no rvalid", cpu_rvalid, 0);
      chk($sformatf("rr%0d host_gnt", k), host_gnt, (k == 4));
      chk($sformatf("rr%0d cpu_gnt", k), cpu_gnt, (k != 4));
      @(negedge clk);
    end
    drv_cpu(0, 0, 0, 0);
    drv_host(0, 0, 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
